// File: rtl/ast_dmx_package.sv
// Shared types and helpers for the Avalon-ST direction merge path.
// Arbiter state encoding and round-robin pointer arithmetic.
package ast_dmx_package;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned rr_next(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ast_rr_arbiter.sv
// Combinational round-robin picker: first request at or above rr_ptr,
// wrapping modulo N.
module ast_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  int idx;

  // Scan downward so the candidate closest to rr_ptr is written last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N;
      if (req[idx]) begin
        grant       = W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ast_arb_mux.sv
// Packet-atomic round-robin merge of RX_DIR Avalon-ST streams into one
// registered output, tagging each beat with its source index.
module ast_arb_mux
  import ast_dmx_package::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]       ast_data_i,
  input  logic [RX_DIR-1:0]                       ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                       ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                       ast_valid_i,
  input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]      ast_empty_i,
  input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]    ast_channel_i,
  output logic [RX_DIR-1:0]                       ast_ready_o,
  output logic [DATA_WIDTH-1:0]                   ast_data_o,
  output logic                                    ast_startofpacket_o,
  output logic                                    ast_endofpacket_o,
  output logic                                    ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]                  ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]                ast_channel_o,
  input  logic                                    ast_ready_i,
  output logic [DIR_SEL_WIDTH-1:0]                dir_o,
  output logic                                    err_o
);

  localparam int unsigned NDIR = RX_DIR;

  arb_state_t state, state_nx;

  logic [DIR_SEL_WIDTH-1:0] grant, grant_nx;
  logic [DIR_SEL_WIDTH-1:0] rr_ptr, rr_nx;
  logic [DIR_SEL_WIDTH-1:0] sel, win;
  logic                     win_vld;
  logic                     out_free;
  logic                     accept;
  logic                     orphan;
  logic [RX_DIR-1:0]        rdy;
  logic [RX_DIR-1:0]        sop_req;
  logic [RX_DIR-1:0]        orphans;

  assign out_free = !ast_valid_o || ast_ready_i;
  assign sop_req  = ast_valid_i & ast_startofpacket_i;
  assign orphans  = ast_valid_i & ~ast_startofpacket_i;

  // Orphan draining must not leak a ready while reset is held.
  assign ast_ready_o = rdy & {RX_DIR{rst_n_i}};

  ast_rr_arbiter #(
    .N (RX_DIR),
    .W (DIR_SEL_WIDTH)
  ) u_arb (
    .req         (sop_req),
    .rr_ptr      (rr_ptr),
    .grant       (win),
    .grant_valid (win_vld)
  );

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr_ptr;
    rdy      = '0;
    sel      = grant;
    accept   = 1'b0;
    orphan   = 1'b0;
    unique case (state)
      IDLE: begin
        rdy    = orphans;
        orphan = |orphans;
        sel    = win;
        if (win_vld) begin
          rdy[win] = out_free;
          accept   = out_free;
          if (out_free) begin
            grant_nx = win;
            if (ast_endofpacket_i[win])
              rr_nx = DIR_SEL_WIDTH'(rr_next(32'(win), NDIR));
            else
              state_nx = LOCKED;
          end
        end
      end
      LOCKED: begin
        rdy[grant] = out_free;
        accept     = out_free && ast_valid_i[grant];
        if (accept && ast_endofpacket_i[grant]) begin
          state_nx = IDLE;
          rr_nx    = DIR_SEL_WIDTH'(rr_next(32'(grant), NDIR));
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
      dir_o               <= '0;
      err_o               <= 1'b0;
    end else begin
      err_o <= orphan;
      if (out_free) begin
        ast_valid_o <= accept;
        if (accept) begin
          ast_data_o          <= ast_data_i[sel];
          ast_startofpacket_o <= ast_startofpacket_i[sel];
          ast_endofpacket_o   <= ast_endofpacket_i[sel];
          ast_empty_o         <= ast_empty_i[sel];
          ast_channel_o       <= ast_channel_i[sel];
          dir_o               <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_ast_arb_mux.sv
// Directed bench for ast_arb_mux: single beat, fairness, backpressure,
// lock hold, orphan drain and asynchronous reset mid-packet.
module tb_ast_arb_mux;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][63:0] data;
  logic [3:0]       sop, eop, vld;
  logic [3:0][2:0]  empty;
  logic [3:0][7:0]  ch;
  logic [3:0]       rdy_o;
  logic [63:0]      data_o;
  logic             sop_o, eop_o, valid_o;
  logic [2:0]       empty_o;
  logic [7:0]       ch_o;
  logic             ready_i;
  logic [1:0]       dir_o;
  logic             err_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          sent[4];
  int          k, b;
  logic [3:0]  r;
  logic        hold;
  logic [63:0] held;

  always #5 clk = ~clk;

  ast_arb_mux dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .ast_data_i          (data),
    .ast_startofpacket_i (sop),
    .ast_endofpacket_i   (eop),
    .ast_valid_i         (vld),
    .ast_empty_i         (empty),
    .ast_channel_i       (ch),
    .ast_ready_o         (rdy_o),
    .ast_data_o          (data_o),
    .ast_startofpacket_o (sop_o),
    .ast_endofpacket_o   (eop_o),
    .ast_valid_o         (valid_o),
    .ast_empty_o         (empty_o),
    .ast_channel_o       (ch_o),
    .ast_ready_i         (ready_i),
    .dir_o               (dir_o),
    .err_o               (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vld   = '0;
    sop   = '0;
    eop   = '0;
    data  = '0;
    empty = '0;
    ch    = '0;
  endtask

  task automatic beat(input int d, input logic s, input logic e,
                      input logic [63:0] dd, input logic [7:0] c,
                      input logic [2:0] em);
    vld[d]   = 1'b1;
    sop[d]   = s;
    eop[d]   = e;
    data[d]  = dd;
    ch[d]    = c;
    empty[d] = em;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state, with an orphan presented while reset is held
    rst_n   = 1'b0;
    ready_i = 1'b0;
    clr();
    beat(1, 1'b0, 1'b0, 64'h55, 8'h0, 3'd0);
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_dir", 64'(dir_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ready", 64'(rdy_o), 64'd0);
    chk("rst_sop", 64'(sop_o), 64'd0);
    clr();
    rst_n = 1'b1;
    tick();

    // single-beat packet from input 2
    ready_i = 1'b1;
    beat(2, 1'b1, 1'b1, 64'h1122334455667788, 8'd5, 3'd3);
    #1;
    chk("t1_ready", 64'(rdy_o), 64'h4);
    tick();
    clr();
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_data", data_o, 64'h1122334455667788);
    chk("t1_chan", 64'(ch_o), 64'd5);
    chk("t1_empty", 64'(empty_o), 64'd3);
    chk("t1_sop", 64'(sop_o), 64'd1);
    chk("t1_eop", 64'(eop_o), 64'd1);
    chk("t1_dir", 64'(dir_o), 64'd2);
    chk("t1_rrptr", 64'(dut.rr_ptr), 64'd3);
    tick();
    chk("t1_drop", 64'(valid_o), 64'd0);

    // fairness: two 3-beat packets per input, all requesting
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) sent[i] = 0;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 24; cyc++) begin
      clr();
      for (int i = 0; i < 4; i++)
        if (sent[i] < 6)
          beat(i, sent[i] % 3 == 0, sent[i] % 3 == 2,
               64'(i * 256 + sent[i]), 8'(i), 3'd0);
      #1;
      r = rdy_o;
      tick();
      for (int i = 0; i < 4; i++)
        if (r[i] && sent[i] < 6) sent[i]++;
      if (valid_o) begin
        chk("fair_data", data_o,
            64'(((k / 3) % 4) * 256 + (k / 12) * 3 + k % 3));
        chk("fair_dir", 64'(dir_o), 64'((k / 3) % 4));
        chk("fair_sop", 64'(sop_o), 64'(k % 3 == 0));
        chk("fair_eop", 64'(eop_o), 64'(k % 3 == 2));
        k++;
      end
    end
    chk("fair_count", 64'(k), 64'd24);
    clr();
    tick();

    // backpressure: 5-beat packet from input 1, random output ready
    do_reset();
    k    = 0;
    b    = 0;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 80 && k < 5; cyc++) begin
      clr();
      if (b < 5)
        beat(1, b == 0, b == 4, 64'(32'hB0 + b), 8'h11,
             (b == 4) ? 3'd2 : 3'd0);
      ready_i = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        chk("bp_hold_valid", 64'(valid_o), 64'd1);
        chk("bp_hold_data", data_o, held);
      end
      if (valid_o) begin
        if (ready_i) begin
          chk("bp_data", data_o, 64'(32'hB0 + k));
          chk("bp_dir", 64'(dir_o), 64'd1);
          chk("bp_eop", 64'(eop_o), 64'(k == 4));
          k++;
          hold = 1'b0;
        end else begin
          held = data_o;
          hold = 1'b1;
        end
      end else begin
        hold = 1'b0;
      end
      r = rdy_o;
      tick();
      if (r[1] && b < 5) b++;
    end
    chk("bp_count", 64'(k), 64'd5);
    ready_i = 1'b1;
    clr();
    tick();

    // lock hold: input 0 gaps for 4 cycles while input 3 waits
    do_reset();
    ready_i = 1'b1;
    clr();
    beat(0, 1'b1, 1'b0, 64'hA0, 8'd0, 3'd0);
    #1;
    chk("lock_first", 64'(rdy_o), 64'h1);
    tick();
    for (int g = 0; g < 4; g++) begin
      clr();
      beat(3, 1'b1, 1'b1, 64'hC3, 8'd3, 3'd0);
      #1;
      chk("lock_stall", 64'(rdy_o), 64'h1);
      chk("lock_gap_valid", 64'(valid_o), 64'(g == 0));
      tick();
    end
    clr();
    beat(0, 1'b0, 1'b1, 64'hA1, 8'd0, 3'd0);
    beat(3, 1'b1, 1'b1, 64'hC3, 8'd3, 3'd0);
    #1;
    chk("lock_eop_ready", 64'(rdy_o), 64'h1);
    tick();
    clr();
    beat(3, 1'b1, 1'b1, 64'hC3, 8'd3, 3'd0);
    #1;
    chk("lock_release", 64'(rdy_o), 64'h8);
    chk("lock_tail_data", data_o, 64'hA1);
    chk("lock_tail_dir", 64'(dir_o), 64'd0);
    tick();
    clr();
    chk("lock_next_data", data_o, 64'hC3);
    chk("lock_next_dir", 64'(dir_o), 64'd3);
    tick();

    // orphan beats in IDLE
    do_reset();
    ready_i = 1'b1;
    clr();
    beat(1, 1'b0, 1'b0, 64'hDEAD, 8'd0, 3'd0);
    #1;
    chk("orph_ready", 64'(rdy_o), 64'h2);
    chk("orph_err_pre", 64'(err_o), 64'd0);
    tick();
    clr();
    chk("orph_err", 64'(err_o), 64'd1);
    chk("orph_valid", 64'(valid_o), 64'd0);
    beat(0, 1'b0, 1'b1, 64'hBAD0, 8'd0, 3'd0);
    beat(2, 1'b0, 1'b0, 64'hBAD2, 8'd0, 3'd0);
    #1;
    chk("orph2_ready", 64'(rdy_o), 64'h5);
    tick();
    clr();
    chk("orph2_err", 64'(err_o), 64'd1);
    chk("orph2_valid", 64'(valid_o), 64'd0);
    tick();
    chk("orph_err_end", 64'(err_o), 64'd0);
    chk("orph_valid_end", 64'(valid_o), 64'd0);

    // asynchronous reset during beat 2 of a 4-beat packet
    do_reset();
    ready_i = 1'b1;
    clr();
    beat(1, 1'b1, 1'b0, 64'hE0, 8'd1, 3'd0);
    tick();
    clr();
    beat(1, 1'b0, 1'b0, 64'hE1, 8'd1, 3'd0);
    tick();
    clr();
    beat(1, 1'b0, 1'b0, 64'hE2, 8'd1, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_data", data_o, 64'd0);
    chk("arst_dir", 64'(dir_o), 64'd0);
    chk("arst_ready", 64'(rdy_o), 64'd0);
    tick();
    clr();
    rst_n = 1'b1;
    beat(3, 1'b1, 1'b1, 64'hF3, 8'd3, 3'd0);
    #1;
    chk("arst_grant", 64'(rdy_o), 64'h8);
    tick();
    clr();
    chk("arst_out_valid", 64'(valid_o), 64'd1);
    chk("arst_out_data", data_o, 64'hF3);
    chk("arst_out_dir", 64'(dir_o), 64'd3);
    chk("arst_err", 64'(err_o), 64'd0);
    tick();
    chk("arst_drop", 64'(valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ast_arb_mux.md
Name: ast_arb_mux

Overview:
- Merges RX_DIR Avalon-ST input streams into one Avalon-ST output stream. This is the merge stage that sits after the per-direction paths fed by the ast demultiplexer.
- Arbitration is round-robin and packet-atomic: once a packet starts, it is forwarded in full before any other input is considered.
- The output is registered, and dir_o reports which input the current output beat came from.

Parameters:
- DATA_WIDTH, 64, data bus width in bits (multiple of 8)
- CHANNEL_WIDTH, 8, channel field width
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width
- RX_DIR, 4, number of input streams (at least 1)
- DIR_SEL_WIDTH, (RX_DIR==1) ? 1 : $clog2(RX_DIR), width of the source index

Ports:
- clk_i  in  1  clock; one clock domain, all logic on the rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- ast_data_i  in  [RX_DIR] x DATA_WIDTH  input data
- ast_startofpacket_i  in  [RX_DIR] x 1  input start of packet
- ast_endofpacket_i  in  [RX_DIR] x 1  input end of packet
- ast_valid_i  in  [RX_DIR] x 1  input valid
- ast_empty_i  in  [RX_DIR] x EMPTY_WIDTH  input empty bytes (meaningful on eop only)
- ast_channel_i  in  [RX_DIR] x CHANNEL_WIDTH  input channel
- ast_ready_o  out  [RX_DIR] x 1  input ready
- ast_data_o  out  DATA_WIDTH  output data
- ast_startofpacket_o  out  1  output start of packet
- ast_endofpacket_o  out  1  output end of packet
- ast_valid_o  out  1  output valid
- ast_empty_o  out  EMPTY_WIDTH  output empty bytes
- ast_channel_o  out  CHANNEL_WIDTH  output channel
- ast_ready_i  in  1  output ready
- dir_o  out  DIR_SEL_WIDTH  source index of the current output beat
- err_o  out  1  one-cycle pulse when an orphan beat is dropped

Behaviour:
- Reset (rst_n_i=0, asynchronous): all outputs go to 0, ast_ready_o goes all 0, state returns to IDLE, rr_ptr goes to 0. Any packet in flight is abandoned. After release, the block starts clean in IDLE.
- Transfer rule: a beat transfers on any edge where valid&&ready. No combinational path runs from ast_ready_i to ast_ready_o except through the slot-free term out_free = !ast_valid_o || ast_ready_i.
- Output register: one stage, so latency is 1 cycle from input acceptance to ast_valid_o.
  - Output data fields hold stable while ast_valid_o && !ast_ready_i.
  - When out_free is high and no beat is accepted, ast_valid_o drops to 0.
- FSM, two states:
  - IDLE:
    - Candidates are inputs with valid && startofpacket. Choose the first candidate scanning from rr_ptr upward, wrapping modulo RX_DIR.
    - The winner's ast_ready_o equals out_free, so the sop beat is accepted in the same cycle as arbitration.
    - On acceptance: latch grant = winner. If eop is also set (single-beat packet), stay in IDLE and set rr_ptr = winner+1 mod RX_DIR. Otherwise move to LOCKED.
  - LOCKED:
    - Only ast_ready_o[grant] = out_free; all other readies are 0.
    - On accepting a beat with eop: go to IDLE and set rr_ptr = grant+1 mod RX_DIR.
    - A beat with sop arriving in LOCKED is forwarded unchanged. It does not restart arbitration.
- Orphan beats:
  - In IDLE, a valid input with sop=0 that is not the winner gets ast_ready_o=1 and is discarded, draining the protocol violation.
  - err_o pulses for 1 cycle; multiple simultaneous orphans still give a single pulse.
  - Orphans never reach the output.
- dir_o is registered alongside the data and equals the grant index of the beat in the output register.
- Bubbles on the granted input (valid=0 in LOCKED) hold the lock indefinitely. There is no timeout.
- RX_DIR=1: arbitration is trivial, and rr_ptr and dir_o stay at 0.

Decomposition:
- Shared package ast_dmx_package:
  - typedef arb_state_t {IDLE, LOCKED}.
  - Function rr_next(ptr, RX_DIR) for the modulo increment.
- One sub-module, ast_rr_arbiter: a purely combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: grant index and grant_valid.
- FSM, orphan logic and output register live in the top.

Test Plan:
- Single packet: input 2 sends one beat (sop=eop=1, data=0x1122334455667788, channel=5, empty=3), ast_ready_i=1 -> one output beat 1 cycle later with identical fields, dir_o=2, rr_ptr becomes 3.
- Fairness: all 4 inputs continuously present 3-beat packets, ast_ready_i=1 -> packet order 0,1,2,3,0,… with no interleaving of beats within any packet.
- Backpressure: a 5-beat packet from input 1 with ast_ready_i random at 50% -> the output beat sequence matches the input exactly, and data is held stable while ast_ready_i=0.
- Lock hold: input 0 is mid-packet with a 4-cycle valid gap while input 3 requests with sop -> input 3 stays stalled until input 0's eop has transferred, then input 3 is granted.
- Orphan: in IDLE, input 1 presents valid=1, sop=0 -> ast_ready_o[1]=1, err_o pulses for 1 cycle, ast_valid_o stays 0.
- Reset mid-packet: assert rst_n_i=0 during beat 2 of a 4-beat packet -> outputs are 0 immediately (asynchronous); after release a new sop from input 3 is granted normally, and err_o=0 unless an orphan tail from the abandoned packet is presented.
